// File: rtl/fuzzy_pkg.sv
// Shared types and constants for the fuzzy coprocessor scheduler.
package fuzzy_pkg;

  localparam int unsigned G_W  = 8;
  localparam int unsigned CH_W = 3;
  localparam logic [G_W-1:0] G_MAX = 8'd100;

  typedef enum logic [1:0] {
    S_IDLE,
    S_ISSUE,
    S_WAIT
  } sched_state_e;

endpackage

// File: rtl/rr_arbiter.sv
// Combinational round-robin arbiter: first pending channel at or after rr_ptr, wrapping.
module rr_arbiter
  import fuzzy_pkg::*;
#(
  parameter int unsigned N = 4
) (
  input  logic [N-1:0]    pending_i,
  input  logic [CH_W-1:0] rr_ptr_i,
  output logic            gnt_valid_o,
  output logic [CH_W-1:0] gnt_idx_o
);

  localparam int unsigned PadW = 1 << CH_W;

  // Zero-padded so a full CH_W-bit index is always in range.
  logic [PadW-1:0] pend_pad;
  logic [CH_W-1:0] idx;

  assign pend_pad = PadW'(pending_i);

  // Scan N positions starting at the pointer; the first hit wins.
  always_comb begin
    gnt_valid_o = 1'b0;
    gnt_idx_o   = '0;
    idx         = '0;
    for (int unsigned k = 0; k < N; k++) begin
      idx = CH_W'((32'(rr_ptr_i) + k) % N);
      if (!gnt_valid_o && pend_pad[idx]) begin
        gnt_valid_o = 1'b1;
        gnt_idx_o   = idx;
      end
    end
  end

endmodule

// File: rtl/fuzzy_sched.sv
// Time-shares one fuzzy core between N_CH channels: RR grant, issue, wait, capture or abort.
module fuzzy_sched
  import fuzzy_pkg::*;
#(
  parameter int unsigned N_CH    = 4,
  parameter int unsigned TIMEOUT = 15
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic [N_CH-1:0]     req,
  input  logic [N_CH*8-1:0]   T_ch,
  input  logic [N_CH*8-1:0]   dT_ch,
  output logic                core_start,
  output logic [7:0]          core_T,
  output logic [7:0]          core_dT,
  input  logic                core_valid,
  input  logic [G_W-1:0]      core_G,
  output logic [N_CH-1:0]     pending,
  output logic                busy,
  output logic                res_valid,
  output logic [CH_W-1:0]     res_ch,
  output logic [G_W-1:0]      res_G,
  output logic [N_CH*G_W-1:0] last_G,
  output logic                err,
  output logic [CH_W-1:0]     err_ch
);

  sched_state_e          state_q;
  logic [N_CH-1:0]       pending_q, pending_d, clr;
  logic [CH_W-1:0]       rr_ptr_q, rr_next;
  logic [CH_W-1:0]       cur_q;
  logic [7:0]            timer_q;
  logic                  core_start_q;
  logic [7:0]            core_t_q, core_dt_q;
  logic                  res_valid_q, err_q;
  logic [CH_W-1:0]       res_ch_q, err_ch_q;
  logic [G_W-1:0]        res_g_q;
  logic [N_CH*G_W-1:0]   last_g_q;
  logic                  gnt_valid;
  logic [CH_W-1:0]       gnt_idx;
  logic                  grant;

  rr_arbiter #(
    .N (N_CH)
  ) u_arb (
    .pending_i   (pending_q),
    .rr_ptr_i    (rr_ptr_q),
    .gnt_valid_o (gnt_valid),
    .gnt_idx_o   (gnt_idx)
  );

  // Pending bits: a new request wins over the grant clear on the same edge.
  always_comb begin
    grant     = (state_q == S_IDLE) && gnt_valid;
    clr       = grant ? ({{(N_CH-1){1'b0}}, 1'b1} << gnt_idx) : '0;
    pending_d = (pending_q & ~clr) | req;
    rr_next   = (gnt_idx == CH_W'(N_CH - 1)) ? '0 : gnt_idx + CH_W'(1);
  end

  // Pending request register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) pending_q <= '0;
    else        pending_q <= pending_d;
  end

  // Scheduler FSM with registered core interface, result and error outputs.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= S_IDLE;
      rr_ptr_q     <= '0;
      cur_q        <= '0;
      timer_q      <= '0;
      core_start_q <= 1'b0;
      core_t_q     <= '0;
      core_dt_q    <= '0;
      res_valid_q  <= 1'b0;
      res_ch_q     <= '0;
      res_g_q      <= '0;
      last_g_q     <= '0;
      err_q        <= 1'b0;
      err_ch_q     <= '0;
    end else begin
      res_valid_q  <= 1'b0;
      err_q        <= 1'b0;
      core_start_q <= 1'b0;
      unique case (state_q)
        S_IDLE: begin
          // core_valid is deliberately ignored here
          if (gnt_valid) begin
            state_q      <= S_ISSUE;
            cur_q        <= gnt_idx;
            rr_ptr_q     <= rr_next;
            core_t_q     <= T_ch[{gnt_idx, 3'b000} +: 8];
            core_dt_q    <= dT_ch[{gnt_idx, 3'b000} +: 8];
            core_start_q <= 1'b1;
          end
        end
        S_ISSUE: begin
          state_q <= S_WAIT;
          timer_q <= 8'd1;
        end
        S_WAIT: begin
          if (core_valid) begin
            state_q                        <= S_IDLE;
            res_valid_q                    <= 1'b1;
            res_ch_q                       <= cur_q;
            res_g_q                        <= core_G;
            last_g_q[{cur_q, 3'b000} +: G_W] <= core_G;
          end else if (timer_q == 8'(TIMEOUT)) begin
            state_q  <= S_IDLE;
            err_q    <= 1'b1;
            err_ch_q <= cur_q;
          end else begin
            timer_q <= timer_q + 8'd1;
          end
        end
        default: state_q <= S_IDLE;
      endcase
    end
  end

  assign core_start = core_start_q;
  assign core_T     = core_t_q;
  assign core_dT    = core_dt_q;
  assign pending    = pending_q;
  assign busy       = (state_q != S_IDLE);
  assign res_valid  = res_valid_q;
  assign res_ch     = res_ch_q;
  assign res_G      = res_g_q;
  assign last_G     = last_g_q;
  assign err        = err_q;
  assign err_ch     = err_ch_q;

endmodule

// File: tb/tb_fuzzy_sched.sv
// Directed bench for fuzzy_sched with a 2-cycle core model (G = T + 25).
module tb_fuzzy_sched;

  localparam int N_CH    = 4;
  localparam int TIMEOUT = 15;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [3:0]  req;
  logic [31:0] T_ch, dT_ch;
  logic        core_start;
  logic [7:0]  core_T, core_dT;
  logic        core_valid;
  logic [7:0]  core_G;
  logic [3:0]  pending;
  logic        busy, res_valid, err;
  logic [2:0]  res_ch, err_ch;
  logic [7:0]  res_G;
  logic [31:0] last_G;

  logic model_en, stray, sd1, mv, start_prev;
  int   n_checks = 0;
  int   n_fail   = 0;
  int   cyc      = 0;
  logic [10:0] res_q[$];
  int   start_q[$];

  fuzzy_sched #(
    .N_CH    (N_CH),
    .TIMEOUT (TIMEOUT)
  ) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .req        (req),
    .T_ch       (T_ch),
    .dT_ch      (dT_ch),
    .core_start (core_start),
    .core_T     (core_T),
    .core_dT    (core_dT),
    .core_valid (core_valid),
    .core_G     (core_G),
    .pending    (pending),
    .busy       (busy),
    .res_valid  (res_valid),
    .res_ch     (res_ch),
    .res_G      (res_G),
    .last_G     (last_G),
    .err        (err),
    .err_ch     (err_ch)
  );

  always #5 clk = ~clk;

  // Core model: valid two cycles after a start, suppressible for timeout tests.
  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sd1 <= 1'b0;
      mv  <= 1'b0;
    end else begin
      sd1 <= core_start;
      mv  <= sd1 & model_en;
    end
  end
  assign core_valid = mv | stray;
  assign core_G     = core_T + 8'd25;

  // Monitor: log results and start rising edges shortly after each clock edge.
  always begin
    @(posedge clk);
    #1;
    cyc++;
    if (rst_n) begin
      if (res_valid) res_q.push_back({res_ch, res_G});
      if (core_start && !start_prev) start_q.push_back(cyc);
      start_prev = core_start;
    end else begin
      start_prev = 1'b0;
    end
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(negedge clk);
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst_n = 1'b0;
    tick();
    rst_n = 1'b1;
  endtask

  task automatic wait_res(input int n, input int budget);
    int k = 0;
    while (res_q.size() < n && k < budget) begin
      tick();
      k++;
    end
    check("res_count", res_q.size(), n);
  endtask

  task automatic wait_idle(input int budget);
    int k = 0;
    while ((busy || pending != 0) && k < budget) begin
      tick();
      k++;
    end
    check("idle", {busy, pending}, 0);
  endtask

  initial begin
    int n;
    rst_n    = 1'b0;
    req      = '0;
    model_en = 1'b1;
    stray    = 1'b0;
    T_ch     = {8'd40, 8'd30, 8'd20, 8'd25};
    dT_ch    = {8'd3, 8'd2, 8'd1, 8'hFD};
    tick();
    tick();
    check("rst_start", core_start, 0);
    check("rst_pend", pending, 0);
    check("rst_outs", {busy, res_valid, res_ch, res_G, err, err_ch, core_T, core_dT}, 0);
    check("rst_lastg", last_G, 0);
    rst_n = 1'b1;

    // Single request: latency and captured values.
    tick();
    req = 4'b0001;
    tick();
    req = 4'b0000;
    check("t1_pend", pending, 4'b0001);
    check("t1_busy", busy, 0);
    tick();
    check("t1_start", core_start, 1);
    check("t1_T", core_T, 25);
    check("t1_dT", core_dT, 8'hFD);
    check("t1_pclr", pending, 0);
    tick();
    check("t1_start_lo", core_start, 0);
    check("t1_busy_wait", busy, 1);
    tick();
    check("t1_no_res", res_valid, 0);
    tick();
    check("t1_res_v", res_valid, 1);
    check("t1_res_ch", res_ch, 0);
    check("t1_res_G", res_G, 50);
    check("t1_lastg0", last_G[7:0], 50);
    tick();
    check("t1_strobe", res_valid, 0);
    check("t1_hold", res_G, 50);

    // Simultaneous requests from rr_ptr=0: order 0..3, starts 4 cycles apart.
    T_ch = {8'd40, 8'd30, 8'd20, 8'd10};
    do_reset();
    res_q.delete();
    start_q.delete();
    req = 4'b1111;
    tick();
    req = 4'b0000;
    wait_res(4, 40);
    check("t2_r0", res_q[0], {3'd0, 8'd35});
    check("t2_r1", res_q[1], {3'd1, 8'd45});
    check("t2_r2", res_q[2], {3'd2, 8'd55});
    check("t2_r3", res_q[3], {3'd3, 8'd65});
    check("t2_nstart", start_q.size(), 4);
    check("t2_gap1", start_q[1] - start_q[0], 4);
    check("t2_gap2", start_q[2] - start_q[1], 4);
    check("t2_gap3", start_q[3] - start_q[2], 4);
    check("t2_lastg", last_G, {8'd65, 8'd55, 8'd45, 8'd35});
    wait_idle(20);
    res_q.delete();
    req = 4'b1111;
    tick();
    req = 4'b0000;
    wait_res(4, 40);
    check("t2_again0", res_q[0], {3'd0, 8'd35});
    wait_idle(20);

    // Fairness: ch0 hammers, ch2 requests once.
    res_q.delete();
    req = 4'b0101;
    tick();
    req = 4'b0001;
    repeat (9) tick();
    req = 4'b0000;
    wait_idle(40);
    check("t3_g0", res_q[0][10:8], 0);
    check("t3_g1", res_q[1][10:8], 2);
    check("t3_g2", res_q[2][10:8], 0);

    // Timeout on ch1, then ch3 served.
    do_reset();
    res_q.delete();
    model_en = 1'b0;
    req = 4'b1010;
    n = 0;
    tick();
    n++;
    req = 4'b0000;
    while (!err && n < 40) begin
      tick();
      n++;
    end
    check("t4_err_time", n, 3 + TIMEOUT);
    check("t4_err_ch", err_ch, 1);
    check("t4_no_res", res_q.size(), 0);
    model_en = 1'b1;
    tick();
    check("t4_err_strobe", err, 0);
    wait_res(1, 20);
    check("t4_next", res_q[0], {3'd3, 8'd65});
    check("t4_lastg1", last_G[15:8], 0);
    wait_idle(20);

    // Merge: req[1] again on the grant edge keeps pending[1]; ch1 runs twice.
    do_reset();
    res_q.delete();
    req = 4'b0010;
    tick();
    check("t5_pend", pending, 4'b0010);
    tick();
    req = 4'b0000;
    check("t5_start", core_start, 1);
    check("t5_kept", pending, 4'b0010);
    wait_res(2, 30);
    check("t5_r0", res_q[0], {3'd1, 8'd45});
    check("t5_r1", res_q[1], {3'd1, 8'd45});
    wait_idle(20);
    stray = 1'b1;
    tick();
    stray = 1'b0;
    check("t5_stray_res", res_valid, 0);
    check("t5_stray_busy", busy, 0);
    repeat (3) tick();
    check("t5_stray_cnt", res_q.size(), 2);

    // Asynchronous reset in the middle of WAIT.
    req = 4'b0001;
    tick();
    req = 4'b0000;
    tick();
    tick();
    check("t6_in_wait", busy, 1);
    #2;
    rst_n = 1'b0;
    #1;
    check("t6_core", {core_start, core_T, core_dT}, 0);
    check("t6_ctl", {busy, pending, err, err_ch}, 0);
    check("t6_res", {res_valid, res_ch, res_G}, 0);
    check("t6_lastg", last_G, 0);
    tick();
    rst_n = 1'b1;
    res_q.delete();
    req = 4'b0100;
    tick();
    req = 4'b0000;
    wait_res(1, 20);
    check("t6_after", res_q[0], {3'd2, 8'd55});

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

  // Global watchdog.
  initial begin
    #20000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

endmodule

// File: doc/fuzzy_sched.md
Name: fuzzy_sched

Overview:
Multi-channel scheduler that time-shares one fuzzy coprocessor core (start-level / valid-pulse interface) between N_CH sensor channels, e.g. temperature zones. Requesters post single-cycle requests. The block arbitrates round-robin, loads the granted channel's T/dT onto the core, and produces a start edge. It then waits for valid, captures G, and returns the result tagged with its channel. It sits between the MMIO/sensor front end and the coprocessor core. The core must run with external dT (dt_mode=0), because the internal estimator cannot be shared between channels.

Parameters:
N_CH, 4, number of requesting channels (2..8)
TIMEOUT, 15, max cycles in WAIT before abort (1..255)

Ports:
clk  in  1  clock
rst_n  in  1  asynchronous active-low reset
req  in  N_CH  per-channel request pulse; bit i = channel i
T_ch  in  N_CH*8  signed Q7.0 T per channel, channel i at [8i+7:8i]
dT_ch  in  N_CH*8  signed Q7.0 dT per channel
core_start  out  1  start level to the core
core_T  out  8  T_in to the core (signed)
core_dT  out  8  dT_in to the core (signed)
core_valid  in  1  core DONE pulse
core_G  in  8  core G_out, 0..100
pending  out  N_CH  outstanding requests
busy  out  1  state != IDLE
res_valid  out  1  1-cycle result strobe
res_ch  out  3  channel of the result
res_G  out  8  result value
last_G  out  N_CH*8  last good G per channel
err  out  1  1-cycle timeout strobe
err_ch  out  3  channel that timed out

Behaviour:
- Reset: all outputs 0. pending=0, rr_ptr=0, state=IDLE, last_G=0.
- pending[i] is set on the edge after req[i]=1. It is cleared on the edge entering ISSUE for channel i. If set and clear hit the same bit in the same cycle, the bit stays 1 (the new request is kept).
- req on a channel that is already pending or in flight merges into a single pending bit. No request is counted twice.
- FSM states:
  - IDLE: if pending!=0, arbitrate, then go to ISSUE. Any core_valid seen in IDLE is ignored.
  - ISSUE: 1 cycle. core_start=1. Then go to WAIT.
  - WAIT: core_start=0 and the timer counts from 1.
    - core_valid=1: capture and go to IDLE.
    - Timer reaches TIMEOUT with no valid: err=1, err_ch=cur, go to IDLE. res_valid is not pulsed and last_G is unchanged.
- Arbitration is round-robin. Search starts at rr_ptr and wraps past N_CH-1 to 0. Grant channel cur; rr_ptr <= (cur+1) mod N_CH on the same edge.
- core_T and core_dT are registered from T_ch[cur] and dT_ch[cur] on the edge entering ISSUE. They hold until the next grant, so the core's inputs stay stable throughout evaluation.
- core_start is registered. It is high only in ISSUE, so there are at least 2 low cycles between successive rising edges.
- Capture, on the edge after a WAIT cycle with core_valid=1:
  - res_valid=1, res_ch=cur, res_G=core_G
  - last_G[cur]=core_G
- res_G and res_ch hold until the next result.
- Latency with the core's 2-cycle valid and an idle scheduler:
  - req at cycle t
  - pending at t+1
  - core_start at t+2
  - core_valid at t+4
  - res_valid at t+5
  - Minimum per-request spacing is therefore 4 cycles (IDLE, ISSUE, WAIT, WAIT).
- A req arriving while busy is queued in pending and served after the current job, in RR order.
- Reset mid-operation: the job is abandoned and everything returns to reset values. The core's own reset covers its state.
- Widths: timer is 8 bits unsigned. cur and err_ch are 3 bits. Channel indices >= N_CH never occur.

Decomposition:
- fuzzy_pkg holds:
  - sched_state_e enum {S_IDLE, S_ISSUE, S_WAIT}
  - G_W=8, CH_W=3
  - G_MAX=8'd100
- Sub-module rr_arbiter (parameter N). Inputs: pending vector, rr_ptr. Outputs: gnt_valid and gnt_idx. Combinational; instantiated once.
- Pending register, FSM, timer and result registers stay in fuzzy_sched.

Test Plan:
- Single request: req=0001, T_ch[0]=25, dT_ch[0]=-3, core model valid 2 cycles after start with G=50 -> core_start at t+2, core_T=25, core_dT=-3, res_valid at t+5, res_ch=0, res_G=50, last_G[0]=50.
- Simultaneous requests: req=1111 in one cycle, rr_ptr=0 -> grants in order 0,1,2,3, starts 4 cycles apart, 4 res_valid strobes. A further req=1111 is then served starting at 0 again.
- RR fairness: ch0 re-requests every cycle while ch2 requests once -> the grant order alternates 0,2,0, and ch2 waits at most one job.
- Timeout: core never asserts valid after the ch1 start -> err=1 with err_ch=1 exactly TIMEOUT cycles after WAIT entry, no res_valid, last_G[1] unchanged, and the next pending channel is then served.
- Merge/collision: req[1] pulsed in the same cycle ch1 enters ISSUE -> pending[1] stays 1, and ch1 is served twice in total. A stray core_valid in IDLE is ignored, with no res_valid.
- Reset mid-WAIT: assert rst_n=0 -> all outputs 0 asynchronously. After release, a req=0100 is served normally with res_ch=2.
